// File: rtl/shift_mac_pkg.sv
// Shared types, constants and helpers for the shift-MAC sequencer.
package shift_mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned W_MAG_MSB  = 2;
  localparam int unsigned W_SIGN_BIT = 3;
  localparam int unsigned PROD_W     = 32;

  // Magnitude zero means no contribution; code 8 is "negative zero".
  function automatic logic is_zero_weight(input logic [W_SIGN_BIT:0] w);
    return (w[W_MAG_MSB:0] == '0);
  endfunction

endpackage

// File: rtl/shift_mac_acc_pipe.sv
// Fetch/PE valid pipeline, product accumulator and skip counter.
module shift_mac_acc_pipe
  import shift_mac_pkg::*;
#(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned ACC_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             rd_en,
  input  logic             sh_skip,
  input  logic [ACC_W-1:0] sh_product,
  output logic             fetch_valid,
  output logic [ACC_W-1:0] acc,
  output logic [LEN_W-1:0] skip_count
);

  logic acc_valid;

  // Track each element from read strobe to PE output, then fold it in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_valid <= 1'b0;
      acc_valid   <= 1'b0;
      acc         <= '0;
      skip_count  <= '0;
    end else begin
      fetch_valid <= rd_en;
      acc_valid   <= fetch_valid;
      if (clear) begin
        acc        <= '0;
        skip_count <= '0;
      end else if (acc_valid) begin
        if (sh_skip) begin
          skip_count <= skip_count + LEN_W'(1);
        end else begin
          acc <= acc + sh_product;
        end
      end
    end
  end

endmodule

// File: rtl/shift_mac_sequencer.sv
// Sequences one log-quantized dot-product job through a shift-based PE.
module shift_mac_sequencer
  import shift_mac_pkg::*;
#(
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned ACC_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_len,
  input  logic [ADDR_W-1:0] i_base_addr,
  output logic              o_busy,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [3:0]        i_w_data,
  input  logic [7:0]        i_a_data,
  output logic              o_sh_skip,
  output logic [3:0]        o_sh_weight,
  output logic [7:0]        o_sh_activation,
  input  logic [ACC_W-1:0]  i_sh_bit_shifted,
  input  logic              i_sh_skip,
  output logic              o_result_valid,
  input  logic              i_result_ready,
  output logic [ACC_W-1:0]  o_result,
  output logic [LEN_W-1:0]  o_skip_count
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              drain_q, drain_d;
  logic              rd_en_d;
  logic [ADDR_W-1:0] addr_d;
  logic              clear_c;
  logic              fetch_valid;

  // Next-state, read-address generation and job-start clear.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    rd_en_d = 1'b0;
    addr_d  = o_rd_addr;
    clear_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          clear_c = 1'b1;
          len_d   = i_len;
          if (i_len != '0) begin
            state_d = RUN;
            rd_en_d = 1'b1;
            addr_d  = i_base_addr;
            cnt_d   = '0;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (cnt_q == len_q - LEN_W'(1)) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end else begin
          rd_en_d = 1'b1;
          addr_d  = o_rd_addr + ADDR_W'(1);
          cnt_d   = cnt_q + LEN_W'(1);
        end
      end
      DRAIN: begin
        if (drain_q) begin
          state_d = DONE;
        end else begin
          drain_d = 1'b1;
        end
      end
      DONE: begin
        if (i_result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and registered control outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      len_q          <= '0;
      cnt_q          <= '0;
      drain_q        <= 1'b0;
      o_rd_en        <= 1'b0;
      o_rd_addr      <= '0;
      o_busy         <= 1'b0;
      o_result_valid <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      cnt_q          <= cnt_d;
      drain_q        <= drain_d;
      o_rd_en        <= rd_en_d;
      o_rd_addr      <= addr_d;
      o_busy         <= (state_d != IDLE);
      o_result_valid <= (state_d == DONE);
    end
  end

  // Buffer data goes straight to the PE; idle slots force skip so the PE holds.
  always_comb begin
    o_sh_skip       = !fetch_valid || is_zero_weight(i_w_data);
    o_sh_weight     = fetch_valid ? i_w_data : 4'd0;
    o_sh_activation = fetch_valid ? i_a_data : 8'd0;
  end

  shift_mac_acc_pipe #(
    .LEN_W (LEN_W),
    .ACC_W (ACC_W)
  ) u_acc_pipe (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear_c),
    .rd_en       (o_rd_en),
    .sh_skip     (i_sh_skip),
    .sh_product  (i_sh_bit_shifted),
    .fetch_valid (fetch_valid),
    .acc         (o_result),
    .skip_count  (o_skip_count)
  );

endmodule
